// File: rtl/alu_issue_if.sv
// alu_issue_if: handshake bundle between register read, the ALU issue stage
// and the ALU. The slave modport is the issue stage's view; the master
// modport is the surrounding pipeline's view.
// Optional macro ALU_ISSUE_ILLEGAL_TRAP_EN adds the illegal flag.
interface alu_issue_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instr;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic          out_valid;
    logic          out_ready;
    logic [11:0]   alu_control;
    logic [DW-1:0] alu_A;
    logic [DW-1:0] alu_B;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic          illegal;
`endif

    modport slave (
        input  in_valid, instr, rs_val, rt_val, out_ready,
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        output illegal,
`endif
        output in_ready, out_valid, alu_control, alu_A, alu_B
    );

    modport master (
        output in_valid, instr, rs_val, rt_val, out_ready,
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        input  illegal,
`endif
        input  in_ready, out_valid, alu_control, alu_A, alu_B
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes a MIPS instruction into the ALU's one-hot control
// code plus operands and buffers the result in a 2-entry queue.
// Outputs come straight from the head-entry registers.
// Optional macro ALU_ISSUE_ILLEGAL_TRAP_EN: undecodable instructions are
// queued with illegal=1 instead of being dropped.
module alu_issue_stage #(
    parameter int DEPTH = 2,
    parameter int DW    = 32
) (
    input  logic         clk,
    input  logic         resetn,
    alu_issue_if.slave   bus
);
    localparam logic [11:0] C_ADD  = 12'h800;
    localparam logic [11:0] C_SUB  = 12'h400;
    localparam logic [11:0] C_SLT  = 12'h200;
    localparam logic [11:0] C_SLTU = 12'h100;
    localparam logic [11:0] C_AND  = 12'h080;
    localparam logic [11:0] C_NOR  = 12'h040;
    localparam logic [11:0] C_OR   = 12'h020;
    localparam logic [11:0] C_XOR  = 12'h010;
    localparam logic [11:0] C_SLL  = 12'h008;
    localparam logic [11:0] C_SRL  = 12'h004;
    localparam logic [11:0] C_SRA  = 12'h002;
    localparam logic [11:0] C_LUI  = 12'h001;

    typedef struct packed {
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        logic          ill;
`endif
        logic [11:0]   ctrl;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } entry_t;

    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [15:0]   imm;
    logic [4:0]    shamt;
    logic          unused_fields;

    logic [11:0]   dec_ctrl;
    logic [DW-1:0] dec_a;
    logic [DW-1:0] dec_b;
    logic          dec_legal;
    entry_t        new_entry;

    entry_t        head_q, head_d;
    entry_t        tail_q, tail_d;
    logic [1:0]    count_q, count_d;

    logic          push;
    logic          enq;
    logic          pop;

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];
    assign imm    = bus.instr[15:0];
    assign shamt  = bus.instr[10:6];
    // Register-number fields are resolved upstream; only operand values arrive here.
    assign unused_fields = ^bus.instr[25:16];

    // Decode opcode/funct into one-hot control and operand selection.
    always_comb begin
        dec_ctrl  = 12'h000;
        dec_a     = bus.rs_val;
        dec_b     = bus.rt_val;
        dec_legal = 1'b1;
        if (opcode == 6'h00) begin
            case (funct)
                6'h20, 6'h21: dec_ctrl = C_ADD;
                6'h22, 6'h23: dec_ctrl = C_SUB;
                6'h2A:        dec_ctrl = C_SLT;
                6'h2B:        dec_ctrl = C_SLTU;
                6'h24:        dec_ctrl = C_AND;
                6'h25:        dec_ctrl = C_OR;
                6'h26:        dec_ctrl = C_XOR;
                6'h27:        dec_ctrl = C_NOR;
                6'h00: begin
                    dec_ctrl = C_SLL;
                    dec_a    = {{(DW-5){1'b0}}, shamt};
                end
                6'h02: begin
                    dec_ctrl = C_SRL;
                    dec_a    = {{(DW-5){1'b0}}, shamt};
                end
                6'h03: begin
                    dec_ctrl = C_SRA;
                    dec_a    = {{(DW-5){1'b0}}, shamt};
                end
                // Variable shifts pass rs through unmasked; the ALU uses the low bits.
                6'h04:        dec_ctrl = C_SLL;
                6'h06:        dec_ctrl = C_SRL;
                6'h07:        dec_ctrl = C_SRA;
                default:      dec_legal = 1'b0;
            endcase
        end else begin
            case (opcode)
                6'h08, 6'h09, 6'h23, 6'h2B: begin
                    dec_ctrl = C_ADD;
                    dec_b    = {{(DW-16){imm[15]}}, imm};
                end
                6'h0A: begin
                    dec_ctrl = C_SLT;
                    dec_b    = {{(DW-16){imm[15]}}, imm};
                end
                6'h0B: begin
                    dec_ctrl = C_SLTU;
                    dec_b    = {{(DW-16){imm[15]}}, imm};
                end
                6'h0C: begin
                    dec_ctrl = C_AND;
                    dec_b    = {{(DW-16){1'b0}}, imm};
                end
                6'h0D: begin
                    dec_ctrl = C_OR;
                    dec_b    = {{(DW-16){1'b0}}, imm};
                end
                6'h0E: begin
                    dec_ctrl = C_XOR;
                    dec_b    = {{(DW-16){1'b0}}, imm};
                end
                6'h0F: begin
                    dec_ctrl = C_LUI;
                    dec_a    = '0;
                    dec_b    = {{(DW-16){1'b0}}, imm};
                end
                default: dec_legal = 1'b0;
            endcase
        end
        if (!dec_legal) begin
            dec_ctrl = 12'h000;
            dec_a    = '0;
            dec_b    = '0;
        end
    end

    // Assemble the entry to enqueue and decide whether it is stored at all.
    always_comb begin
        new_entry.ctrl = dec_ctrl;
        new_entry.a    = dec_a;
        new_entry.b    = dec_b;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        new_entry.ill  = ~dec_legal;
        enq            = push;
`else
        // Illegal words are accepted but dropped, so they never occupy a slot.
        enq            = push & dec_legal;
`endif
    end

    // in_ready depends on the count only, keeping out_ready off the input path.
    assign bus.in_ready  = (count_q != 2'(DEPTH));
    assign bus.out_valid = (count_q != 2'd0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // Queue next-state: head is slot 0, tail is slot 1.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            2'd0: begin
                if (enq) begin
                    head_d  = new_entry;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (enq && pop) begin
                    head_d = new_entry;
                end else if (enq) begin
                    tail_d  = new_entry;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    // Queue state registers; reset empties the queue and clears the outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign bus.alu_control = head_q.ctrl;
    assign bus.alu_A       = head_q.a;
    assign bus.alu_B       = head_q.b;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    assign bus.illegal     = head_q.ill;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors with hand-computed expectations for
// alu_issue_stage. Builds with or without ALU_ISSUE_ILLEGAL_TRAP_EN.
module tb_alu_issue_stage;
    logic clk;
    logic resetn;
    int   n_total;
    int   n_pass;

    alu_issue_if #(.DW(32)) bus ();

    alu_issue_stage #(.DEPTH(2), .DW(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ctrl;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the push edge.
    task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        bus.instr    = ins;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] ctrl,
                            input logic [31:0] a, input logic [31:0] b);
        chk({tag, "_vld"},  32'(bus.out_valid), 32'd1);
        chk({tag, "_ctrl"}, 32'(bus.alu_control), ctrl);
        chk({tag, "_A"},    bus.alu_A, a);
        chk({tag, "_B"},    bus.alu_B, b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        clk     = 1'b0;
        resetn  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.rs_val    = '0;
        bus.rt_val    = '0;
        bus.out_ready = 1'b0;

        vecs[0]  = '{32'h2000FFFC, 32'd10,   32'h77,       32'h800, 32'd10,   32'hFFFFFFFC};
        vecs[1]  = '{32'h34008001, 32'd3,    32'h77,       32'h020, 32'd3,    32'h00008001};
        vecs[2]  = '{32'h3C001234, 32'h55,   32'h77,       32'h001, 32'd0,    32'h00001234};
        vecs[3]  = '{32'h00000103, 32'h99,   32'h80000000, 32'h002, 32'd4,    32'h80000000};
        vecs[4]  = '{32'h00000006, 32'd33,   32'hF0,       32'h004, 32'd33,   32'hF0};
        vecs[5]  = '{32'h28008000, 32'd7,    32'h77,       32'h200, 32'd7,    32'hFFFF8000};
        vecs[6]  = '{32'h30008000, 32'd7,    32'h77,       32'h080, 32'd7,    32'h00008000};
        vecs[7]  = '{32'h00000027, 32'hA,    32'hB,        32'h040, 32'hA,    32'hB};
        vecs[8]  = '{32'h0000002B, 32'd1,    32'd2,        32'h100, 32'd1,    32'd2};
        vecs[9]  = '{32'h000007C0, 32'h99,   32'd1,        32'h008, 32'd31,   32'd1};
        vecs[10] = '{32'h3800FFFF, 32'h5,    32'h6,        32'h010, 32'h5,    32'h0000FFFF};
        vecs[11] = '{32'hAC00FFFF, 32'h100,  32'h6,        32'h800, 32'h100,  32'hFFFFFFFF};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ctrl",      32'(bus.alu_control), 32'd0);
        chk("rst_A",         bus.alu_A, 32'd0);
        chk("rst_B",         bus.alu_B, 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        chk("rst_illegal",   32'(bus.illegal), 32'd0);
`endif
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready), 32'd1);

        // addu $2,$4,$5 with one-cycle latency
        bus.out_ready = 1'b1;
        issue(32'h00851021, 32'd5, 32'd7);
        chk_head("addu", 32'h800, 32'd5, 32'd7);

        // Illegal opcode arrives while addu is popped
        issue(32'hFC000000, 32'd1, 32'd2);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        chk_head("ill_op", 32'h000, 32'd0, 32'd0);
        chk("ill_op_flag", 32'(bus.illegal), 32'd1);
`else
        chk("ill_op_dropped", 32'(bus.out_valid), 32'd0);
`endif
        // Illegal R-type funct
        issue(32'h00000001, 32'd1, 32'd2);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        chk_head("ill_fn", 32'h000, 32'd0, 32'd0);
        chk("ill_fn_flag", 32'(bus.illegal), 32'd1);
`else
        chk("ill_fn_dropped", 32'(bus.out_valid), 32'd0);
`endif
        // out_ready with an empty queue has no effect
        repeat (2) @(negedge clk);
        chk("empty_out_valid", 32'(bus.out_valid), 32'd0);
        chk("empty_in_ready",  32'(bus.in_ready), 32'd1);

        // Backpressure: two accepted, third held
        bus.out_ready = 1'b0;
        bus.instr = 32'h00000020; bus.rs_val = 32'd1; bus.rt_val = 32'd2; bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp_ready_after1", 32'(bus.in_ready), 32'd1);
        bus.instr = 32'h00000022; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
        @(posedge clk); @(negedge clk);
        bus.instr = 32'h00000025; bus.rs_val = 32'd5; bus.rt_val = 32'd6;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            chk_head("bp_stall", 32'h800, 32'd1, 32'd2);
            @(posedge clk); @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_head("bp_drain2", 32'h400, 32'd3, 32'd4);
        chk("bp_ready_again", 32'(bus.in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        chk_head("bp_drain3", 32'h020, 32'd5, 32'd6);
        @(posedge clk); @(negedge clk);
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // Streaming: one result per cycle, queue never fills
        for (int i = 0; i < 12; i++) begin
            bus.instr    = vecs[i].instr;
            bus.rs_val   = vecs[i].rs;
            bus.rt_val   = vecs[i].rt;
            bus.in_valid = 1'b1;
            @(posedge clk); @(negedge clk);
            chk_head($sformatf("stream%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b);
            chk($sformatf("stream%0d_rdy", i), 32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("stream_empty", 32'(bus.out_valid), 32'd0);

        // Reset while full
        bus.out_ready = 1'b0;
        issue(32'h00000020, 32'd1, 32'd2);
        issue(32'h00000022, 32'd3, 32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_ctrl",      32'(bus.alu_control), 32'd0);
        chk("midrst_A",         bus.alu_A, 32'd0);
        chk("midrst_B",         bus.alu_B, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready",  32'(bus.in_ready), 32'd1);
        chk("postrst_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        issue(32'h00851021, 32'd9, 32'd8);
        chk_head("postrst_addu", 32'h800, 32'd9, 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
